// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED pattern sequencer
//
// Purpose: mode and direction enums, per-mode initial LED patterns and a
//          lookup helper used by the sequencer top.
// Ports:   none (package).

package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_SHL    = 2'd0,
      MODE_SHR    = 2'd1,
      MODE_FILL   = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_e;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_e;

   localparam logic [7:0] INIT_SHL    = 8'h01;
   localparam logic [7:0] INIT_SHR    = 8'h80;
   localparam logic [7:0] INIT_FILL   = 8'h00;
   localparam logic [7:0] INIT_BOUNCE = 8'h01;

   function automatic logic [7:0] init_pattern(input mode_e m);
      logic [7:0] p;
      case (m)
         MODE_SHL:    p = INIT_SHL;
         MODE_SHR:    p = INIT_SHR;
         MODE_FILL:   p = INIT_FILL;
         MODE_BOUNCE: p = INIT_BOUNCE;
         default:     p = INIT_SHL;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// rtl/led_pattern_sequencer_step_prescaler.sv - divides the clock into pattern step strobes
//
// Purpose: counts enabled clocks and flags a step on the cycle whose edge
//          wraps the counter from DIV-1 back to 0.
// Ports:   clk  - system clock, rising edge
//          rst  - asynchronous active-high reset
//          en   - count enable; 0 holds the counter
//          clr  - synchronous clear, overrides en and suppresses the step
//          step - combinational, high when the next edge is a step edge

module step_prescaler #(
   parameter int unsigned DIV = 25_000_000,
   parameter int unsigned CW  = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // A clear (mode restart) always beats a wrap landing on the same edge.
   assign step = en && !clr && (cnt == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - drives 8 LEDs with one of four step patterns
//
// Purpose: synchronizes the requested mode, restarts the pattern whenever the
//          synchronized mode differs from the running one, and advances the
//          selected pattern on each prescaler step.
// Ports:   clk    - system clock, rising edge
//          rst    - asynchronous active-high reset
//          en     - run enable; 0 freezes prescaler and pattern
//          mode_i - requested mode, asynchronous to clk
//          led_o  - registered LED pattern
//          mode_o - registered mode currently executing
//          tick_o - one-cycle pulse in the cycle after each pattern advance

module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned DIV = 25_000_000,
   parameter int unsigned CW  = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode_i,
   output logic [7:0] led_o,
   output logic [1:0] mode_o,
   output logic       tick_o
);

   logic [1:0] mode_s1;
   logic [1:0] mode_s2;

   mode_e      mode_q, mode_d;
   dir_e       dir_q,  dir_d;
   logic [7:0] led_q,  led_d;
   logic       tick_q, tick_d;

   logic       mode_change;
   logic       step;

   assign mode_change = (mode_s2 != mode_q);

   step_prescaler #(
      .DIV (DIV),
      .CW  (CW)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (mode_change),
      .step (step)
   );

   // State register, including the two-flop mode synchronizer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_s1 <= 2'd0;
         mode_s2 <= 2'd0;
         mode_q  <= MODE_SHL;
         dir_q   <= LEFT;
         led_q   <= INIT_SHL;
         tick_q  <= 1'b0;
      end else begin
         mode_s1 <= mode_i;
         mode_s2 <= mode_s1;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         led_q   <= led_d;
         tick_q  <= tick_d;
      end
   end

   // Next-state logic: restart on any mode difference, else step the pattern.
   always_comb begin
      mode_d = mode_q;
      dir_d  = dir_q;
      led_d  = led_q;
      tick_d = 1'b0;

      if (mode_change) begin
         mode_d = mode_e'(mode_s2);
         led_d  = init_pattern(mode_e'(mode_s2));
         dir_d  = LEFT;
      end else if (step) begin
         tick_d = 1'b1;
         dir_d  = LEFT;
         case (mode_q)
            MODE_SHL: begin
               led_d = {led_q[6:0], led_q[7]};
            end
            MODE_SHR: begin
               led_d = {led_q[0], led_q[7:1]};
            end
            MODE_FILL: begin
               // Full bar empties in one step so the period is 9, not 8.
               if (led_q == 8'hFF) begin
                  led_d = 8'h00;
               end else begin
                  led_d = {led_q[6:0], 1'b1};
               end
            end
            MODE_BOUNCE: begin
               // Turn around on the step that would hit the end, so the end
               // LED is shown once and never repeated.
               if (dir_q == LEFT) begin
                  if (led_q[7]) begin
                     dir_d = RIGHT;
                     led_d = led_q >> 1;
                  end else begin
                     led_d = led_q << 1;
                  end
               end else begin
                  if (led_q[0]) begin
                     dir_d = LEFT;
                     led_d = led_q << 1;
                  end else begin
                     dir_d = RIGHT;
                     led_d = led_q >> 1;
                  end
               end
            end
            default: begin
               led_d = led_q;
            end
         endcase
      end
   end

   // Outputs are straight from registers.
   always_comb begin
      led_o  = led_q;
      mode_o = mode_q;
      tick_o = tick_q;
   end

   // Every mode except FILL keeps exactly one LED lit.
   onehot_pattern_a : assert property (
      @(posedge clk) disable iff (rst)
         (mode_q != MODE_FILL) |-> $onehot(led_q)
   );

endmodule
